// File: rtl/lcd_ctrl_param_if.sv
// Command strobe plus IROM/IRAM buses of the parametrised LCD image controller.
// The controller uses the slave view; the environment drives through the master view.
interface lcd_ctrl_param_if #(
  parameter int DW = 8,
  parameter int AW = 3
) ();
  localparam int AAW = 2 * AW;

  logic [3:0]     cmd;
  logic           cmd_valid;
  logic           busy;
  logic           IROM_rd;
  logic [AAW-1:0] IROM_A;
  logic [DW-1:0]  IROM_Q;
  logic           IRAM_valid;
  logic [AAW-1:0] IRAM_A;
  logic [DW-1:0]  IRAM_D;
  logic           done;

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output busy, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, done
  );

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  busy, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// N x N image controller: loads from IROM, edits a 2x2 window on command,
// dumps the buffer to IRAM on Write and then returns to IDLE.
module lcd_ctrl_param #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input logic          clk,
  input logic          reset,
  lcd_ctrl_param_if.slave bus
);
  localparam int N    = 1 << AW;
  localparam int NPIX = N * N;
  localparam int AAW  = 2 * AW;
  localparam logic [AW-1:0]  ORG  = AW'(N / 2 - 1);
  localparam logic [AW-1:0]  EDGE = AW'(N - 2);
  localparam logic [AAW-1:0] LAST = AAW'(NPIX - 1);

  typedef enum logic [1:0] {LOAD, IDLE, EXEC, WRITE} state_t;

  state_t         state;
  logic [DW-1:0]  pix_mem [NPIX];
  logic [AW-1:0]  ox, oy;
  logic [3:0]     cmd_p0;
  logic           cap_vld_p0;
  logic [AAW-1:0] cap_addr_p0;
  logic           busy, rom_rd, ram_vld, done_r;
  logic [AAW-1:0] rom_a, ram_a;
  logic [DW-1:0]  ram_d;

  logic [AAW-1:0] a0, a1, a2, a3;
  logic [DW-1:0]  p0, p1, p2, p3, n0, n1, n2, n3;
  logic [DW-1:0]  wmax, wmin, wavg;
  logic           win_wr;

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Two guard bits keep the four-way sum exact; the shift floors it.
  function automatic logic [DW-1:0] avg4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return sum[DW+1:2];
  endfunction

  assign a0 = {oy, ox};
  assign a1 = {oy, ox + AW'(1)};
  assign a2 = {oy + AW'(1), ox};
  assign a3 = {oy + AW'(1), ox + AW'(1)};
  assign p0 = pix_mem[a0];
  assign p1 = pix_mem[a1];
  assign p2 = pix_mem[a2];
  assign p3 = pix_mem[a3];
  assign wmax = max2(max2(p0, p1), max2(p2, p3));
  assign wmin = min2(min2(p0, p1), min2(p2, p3));
  assign wavg = avg4(p0, p1, p2, p3);

  always_comb begin
    n0 = p0;
    n1 = p1;
    n2 = p2;
    n3 = p3;
    win_wr = 1'b1;
    case (cmd_p0)
      4'h5: begin n0 = wmax; n1 = wmax; n2 = wmax; n3 = wmax; end
      4'h6: begin n0 = wmin; n1 = wmin; n2 = wmin; n3 = wmin; end
      4'h7: begin n0 = wavg; n1 = wavg; n2 = wavg; n3 = wavg; end
      4'h8: begin n0 = p1; n1 = p3; n2 = p0; n3 = p2; end
      4'h9: begin n0 = p2; n1 = p0; n2 = p3; n3 = p1; end
      4'hA: begin n0 = p2; n1 = p3; n2 = p0; n3 = p1; end
      4'hB: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
      default: win_wr = 1'b0;
    endcase
  end

  // Control and registered outputs; capture stage _p0 trails the ROM address by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      busy        <= 1'b1;
      rom_rd      <= 1'b1;
      rom_a       <= '0;
      ram_vld     <= 1'b0;
      ram_a       <= '0;
      ram_d       <= '0;
      done_r      <= 1'b0;
      ox          <= ORG;
      oy          <= ORG;
      cmd_p0      <= '0;
      cap_vld_p0  <= 1'b0;
      cap_addr_p0 <= '0;
    end else begin
      cap_vld_p0  <= rom_rd;
      cap_addr_p0 <= rom_a;
      case (state)
        LOAD: begin
          if (rom_rd) begin
            if (rom_a == LAST) rom_rd <= 1'b0;
            else               rom_a  <= rom_a + AAW'(1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_p0 <= bus.cmd;
            busy   <= 1'b1;
            if (bus.cmd == 4'h0) begin
              state   <= WRITE;
              ram_vld <= 1'b1;
              ram_a   <= '0;
              ram_d   <= pix_mem[AAW'(0)];
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          state <= IDLE;
          busy  <= 1'b0;
          case (cmd_p0)
            4'h1: if (oy != '0)  oy <= oy - AW'(1);
            4'h2: if (oy != EDGE) oy <= oy + AW'(1);
            4'h3: if (ox != '0)  ox <= ox - AW'(1);
            4'h4: if (ox != EDGE) ox <= ox + AW'(1);
            4'hC: begin ox <= ORG; oy <= ORG; end
            default: ;
          endcase
        end
        WRITE: begin
          if (ram_vld) begin
            if (ram_a == LAST) begin
              ram_vld <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              ram_a <= ram_a + AAW'(1);
              ram_d <= pix_mem[ram_a + AAW'(1)];
            end
          end else begin
            done_r <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Pixel buffer: ROM capture during LOAD, window rewrite at the end of EXEC.
  always_ff @(posedge clk) begin
    if (cap_vld_p0) pix_mem[cap_addr_p0] <= bus.IROM_Q;
    if (state == EXEC && win_wr) begin
      pix_mem[a0] <= n0;
      pix_mem[a1] <= n1;
      pix_mem[a2] <= n2;
      pix_mem[a3] <= n3;
    end
  end

  assign bus.busy       = busy;
  assign bus.IROM_rd    = rom_rd;
  assign bus.IROM_A     = rom_a;
  assign bus.IRAM_valid = ram_vld;
  assign bus.IRAM_A     = ram_a;
  assign bus.IRAM_D     = ram_d;
  assign bus.done       = done_r;
endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
Parametrised image display controller, the next generation of the 8x8/8-bit fixed controller.
- Loads an N x N pixel image (N = 2^AW, DW-bit pixels) from IROM into an internal buffer.
- Executes window commands on a 2x2 operating window.
- Dumps the buffer to IRAM on request.
- New behaviour: configurable size/width; a Reset-Origin command; Write is non-terminal (after a dump, done pulses and the block returns to IDLE for further commands and dumps).

Parameters:
DW, 8, pixel width in bits
AW, 3, log2 of image side; N = 2^AW, NPIX = N*N, address width AAW = 2*AW

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd  in  4  command code
cmd_valid  in  1  command strobe, sampled only when busy=0
busy  out  1  block not accepting commands
IROM_rd  out  1  ROM read enable
IROM_A  out  AAW  ROM address
IROM_Q  in  DW  ROM data, valid one cycle after IROM_A presented with IROM_rd=1
IRAM_valid  out  1  write strobe to IRAM
IRAM_A  out  AAW  IRAM address
IRAM_D  out  DW  IRAM data
done  out  1  one-cycle pulse after final dump word

Behaviour:
- Reset (asynchronous, any state incl. mid-dump):
  - state=LOAD, busy=1, IROM_rd=1, IROM_A=0.
  - IRAM_valid=0, IRAM_A=0, IRAM_D=0, done=0.
  - Origin (x,y) = (N/2-1, N/2-1). Buffer contents undefined until reloaded.
- Window pixels, address = y*N+x:
  - P0=(x,y), P1=(x+1,y), P2=(x,y+1), P3=(x+1,y+1).
- States: LOAD, IDLE, EXEC, WRITE.
- LOAD:
  - Cycle k (k=0..NPIX-1): IROM_rd=1, IROM_A=k.
  - Cycle k+1: IROM_Q captured into buf[k].
  - After address NPIX-1: IROM_rd=0, IROM_A holds NPIX-1. Last capture happens, then IDLE.
  - busy first low NPIX+1 cycles after reset release.
- IDLE: busy=0.
  - cmd_valid=1 with cmd=0 -> WRITE.
  - cmd_valid=1 with any other cmd -> EXEC.
  - Otherwise stay in IDLE.
- EXEC: exactly one cycle, busy=1, command applied at end of cycle, then IDLE.
- cmd_valid while busy=1: ignored, not queued.
- Command codes:
  - 1 Up: y=max(y-1,0).
  - 2 Down: y=min(y+1,N-2).
  - 3 Left: x=max(x-1,0).
  - 4 Right: x=min(x+1,N-2).
  - 5 Max: P0..P3 <= largest of the four.
  - 6 Min: P0..P3 <= smallest of the four.
  - 7 Average: sum computed at DW+2 bits, no overflow; P0..P3 <= floor(sum/4).
  - 8 CCW: P0<=P1, P1<=P3, P3<=P2, P2<=P0, all from pre-command values.
  - 9 CW: P0<=P2, P2<=P3, P3<=P1, P1<=P0.
  - A MirrorX: swap P0<->P2, P1<->P3.
  - B MirrorY: swap P0<->P1, P2<->P3.
  - C ResetOrigin: origin <= (N/2-1, N/2-1).
  - D-F: no-op; still one EXEC cycle.
- Shifts at the boundary leave the origin unchanged; the buffer is never touched by shifts.
- WRITE: busy=1 throughout.
  - Cycles j=0..NPIX-1: IRAM_valid=1, IRAM_A=j, IRAM_D=buf[j], all registered.
  - Cycle after j=NPIX-1: IRAM_valid=0, done=1 for one cycle, busy=1.
  - Next cycle: IDLE, busy=0, done=0.
  - IRAM_A/IRAM_D hold their last values when IRAM_valid=0.
- Buffer is unchanged by WRITE. Repeated dumps are identical unless an intervening command modifies the buffer.
- IROM_rd=0 in every state except LOAD.

Test Plan:
- N=8, DW=8, ROM[a]=a, Write immediately -> busy falls 65 cycles after reset release; IRAM_A=0..63 with IRAM_D=a; done pulses exactly once the cycle after A=63; busy low next cycle.
- Ramp ROM, five Up then Max -> origin (3,0); addresses 3,4,11,12 all 12 in dump; a sixth Up leaves the origin at y=0.
- ROM[27,28,35,36]=255,255,255,254, Average -> all four 254 (1019>>2), no wrap; Min on 0,1,2,3 -> all 0.
- Ramp ROM, CW at default origin -> buf[27]=35, buf[28]=27, buf[36]=28, buf[35]=36; then CCW restores the ramp; MirrorY twice restores.
- Write, then Right, Max, ResetOrigin, Write -> second dump differs only at 28,29,36,37 (all 37); origin back to (3,3). cmd_valid pulses during busy produce no effect.
- Reset asserted mid-dump at IRAM_A=20 -> all outputs at reset values immediately, full reload, correct dump afterwards; repeat with AW=4, DW=10: 257-cycle load, 256-word dump.
